// File: rtl/pixel_pack_writer.sv
// Packs PPW camera pixels into one SRAM word and writes words through a 2-entry buffer over
// a req/ready handshake. Frames are bounded by vsync and an optional end-of-image marker.
module pixel_pack_writer #(
   parameter int                 PIX_W      = 8,
   parameter int                 PPW        = 2,
   parameter int                 ADDR_W     = 16,
   parameter logic [2*PIX_W-1:0] EOF_MARKER = 16'hFFD9,
   parameter bit                 EOF_EN     = 1'b1,
   parameter logic               VSYNC_ACT  = 1'b0,
   parameter logic [PIX_W-1:0]   PAD_PIX    = 8'h00
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vsync,
   input  logic                 pixel_valid,
   input  logic [PIX_W-1:0]     pixel_data,
   input  logic [ADDR_W-1:0]    pixel_addr,
   output logic                 sram_req,
   input  logic                 sram_ready,
   output logic [ADDR_W-1:0]    sram_addr,
   output logic [PIX_W*PPW-1:0] sram_data,
   output logic                 frame_end,
   output logic                 err_overflow,
   output logic                 err_vsync,
   output logic                 capture_rst_n
);

   localparam int WORD_W = PIX_W * PPW;
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int SHIFT  = $clog2(PPW);
   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(PPW - 1);

   typedef enum logic [1:0] {WAIT_ACT, WAIT_IDLE, CAPTURE, FLUSH} state_e;

   state_e            state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  prev_q, prev_d;
   logic [ADDR_W-1:0] fifo_addr_q [2];
   logic [ADDR_W-1:0] fifo_addr_d [2];
   logic [WORD_W-1:0] fifo_data_q [2];
   logic [WORD_W-1:0] fifo_data_d [2];
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic              frame_end_q, frame_end_d;
   logic              err_ovf_q, err_ovf_d, err_vs_q, err_vs_d;

   logic              vsync_act, hit, push, push_ok, pop;
   logic [ADDR_W-1:0] push_addr;
   logic [WORD_W-1:0] push_data;

   assign sram_req      = (count_q != 2'd0);
   assign sram_addr     = fifo_addr_q[rd_ptr_q];
   assign sram_data     = fifo_data_q[rd_ptr_q];
   assign frame_end     = frame_end_q;
   assign err_overflow  = err_ovf_q;
   assign err_vsync     = err_vs_q;
   assign capture_rst_n = (state_q == CAPTURE) || (state_q == FLUSH);

   always_comb begin
      // NOTE: every value written here gets a default first, so no path leaves a latch behind.
      state_d     = state_q;
      lane_d      = lane_q;
      word_d      = word_q;
      addr_d      = addr_q;
      prev_d      = prev_q;
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      frame_end_d = 1'b0;
      err_ovf_d   = err_ovf_q;
      err_vs_d    = err_vs_q;
      push        = 1'b0;
      push_ok     = 1'b0;
      hit         = 1'b0;
      vsync_act   = (vsync == VSYNC_ACT);
      pop         = sram_req && sram_ready;

      // Outgoing word: lanes already packed, the current pixel, then padding.
      push_addr = ((lane_q == '0) ? pixel_addr : addr_q) >> SHIFT;
      push_data = '0;
      for (int k = 0; k < PPW; k++) begin
         if (k < int'(lane_q))       push_data[k*PIX_W +: PIX_W] = word_q[k*PIX_W +: PIX_W];
         else if (k == int'(lane_q)) push_data[k*PIX_W +: PIX_W] = pixel_data;
         else                        push_data[k*PIX_W +: PIX_W] = PAD_PIX;
      end

      case (state_q)
         WAIT_ACT: begin
            if (vsync_act) state_d = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (!vsync_act) begin
               state_d = CAPTURE;
               lane_d  = '0;
               prev_d  = '0;
            end
         end
         CAPTURE: begin
            if (vsync_act) begin
               err_vs_d = 1'b1;
               lane_d   = '0;
               state_d  = FLUSH;
            end else if (pixel_valid) begin
               hit = EOF_EN && ({prev_q, pixel_data} == EOF_MARKER);
               word_d[int'(lane_q)*PIX_W +: PIX_W] = pixel_data;
               if (lane_q == '0) addr_d = pixel_addr;
               prev_d = pixel_data;
               push   = (lane_q == LANE_MAX) || hit;
               lane_d = push ? '0 : lane_q + 1'b1;
               if (hit) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (count_q == 2'd0) begin
               frame_end_d = 1'b1;
               state_d     = WAIT_IDLE;
            end
         end
         default: state_d = WAIT_ACT;
      endcase

      // A pop in the same cycle frees the slot, so a full buffer can still take the push.
      if (push) begin
         if ((count_q != 2'd2) || pop) begin
            push_ok                 = 1'b1;
            fifo_addr_d[wr_ptr_q]   = push_addr;
            fifo_data_d[wr_ptr_q]   = push_data;
            wr_ptr_d                = ~wr_ptr_q;
         end else begin
            err_ovf_d = 1'b1;
         end
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push_ok && !pop)      count_d = count_q + 2'd1;
      else if (!push_ok && pop) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_ACT;
         lane_q      <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         prev_q      <= '0;
         count_q     <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         frame_end_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_vs_q    <= 1'b0;
         // NOTE: buffer storage is reset because the head entry drives sram_addr/sram_data directly.
         for (int i = 0; i < 2; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state_q     <= state_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         prev_q      <= prev_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         frame_end_q <= frame_end_d;
         err_ovf_q   <= err_ovf_d;
         err_vs_q    <= err_vs_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
      end
   end

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Scoreboard bench for pixel_pack_writer: a PPW=2 and a PPW=4 instance share clock, reset,
// vsync and pixel bus; each has its own valid/ready and expected-word queue.
module tb_pixel_pack_writer;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic [7:0]  pixel_data;
   logic [15:0] pixel_addr;

   logic        valid2, ready2, req2, fe2, ovf2, verr2, cap2;
   logic [15:0] addr2;
   logic [15:0] data2;
   logic        valid4, ready4, req4, fe4, ovf4, verr4, cap4;
   logic [15:0] addr4;
   logic [31:0] data4;

   exp_t q2[$];
   exp_t q4[$];
   exp_t e2, e4;

   int n_checks = 0;
   int n_fail   = 0;
   int acc2 = 0, acc4 = 0, req_hi2 = 0, fe2_cnt = 0, fe4_cnt = 0;
   logic cap_at_fe4 = 1'b1;
   int base;

   always #5 clk = ~clk;

   pixel_pack_writer #(.PPW(2)) u_dut2 (
      .clk(clk), .reset(reset), .vsync(vsync), .pixel_valid(valid2),
      .pixel_data(pixel_data), .pixel_addr(pixel_addr), .sram_req(req2),
      .sram_ready(ready2), .sram_addr(addr2), .sram_data(data2), .frame_end(fe2),
      .err_overflow(ovf2), .err_vsync(verr2), .capture_rst_n(cap2)
   );

   pixel_pack_writer #(.PPW(4)) u_dut4 (
      .clk(clk), .reset(reset), .vsync(vsync), .pixel_valid(valid4),
      .pixel_data(pixel_data), .pixel_addr(pixel_addr), .sram_req(req4),
      .sram_ready(ready4), .sram_addr(addr4), .sram_data(data4), .frame_end(fe4),
      .err_overflow(ovf4), .err_vsync(verr4), .capture_rst_n(cap4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit to4, input logic [7:0] d, input logic [15:0] a);
      pixel_data = d;
      pixel_addr = a;
      if (to4) valid4 = 1'b1; else valid2 = 1'b1;
      tick(1);
      valid2 = 1'b0;
      valid4 = 1'b0;
      tick(1);
   endtask

   task automatic push2(input logic [15:0] a, input logic [31:0] d);
      q2.push_back('{addr: a, data: d});
   endtask

   task automatic push4(input logic [15:0] a, input logic [31:0] d);
      q4.push_back('{addr: a, data: d});
   endtask

   // Bounded wait for a frame_end count to reach target; an expired bound is a failed check.
   task automatic wait_fe(input bit on4, input int target, input string tag);
      for (int i = 0; i < 50; i++) begin
         if ((on4 ? fe4_cnt : fe2_cnt) >= target) break;
         tick(1);
      end
      check(tag, on4 ? fe4_cnt : fe2_cnt, target);
   endtask

   // Accepts happen at the next rising edge when req && ready is seen here.
   always @(negedge clk) begin
      if (!reset) begin
         if (req2) req_hi2++;
         if (fe2) fe2_cnt++;
         if (fe4) begin
            fe4_cnt++;
            cap_at_fe4 = cap4;
         end
         if (req2 && ready2) begin
            acc2++;
            if (q2.size() == 0) check("dut2 unexpected write", {addr2, data2}, 0);
            else begin
               e2 = q2.pop_front();
               check("dut2 addr", addr2, e2.addr);
               check("dut2 data", data2, e2.data[15:0]);
            end
         end
         if (req4 && ready4) begin
            acc4++;
            if (q4.size() == 0) check("dut4 unexpected write", {addr4, data4}, 0);
            else begin
               e4 = q4.pop_front();
               check("dut4 addr", addr4, e4.addr);
               check("dut4 data", data4, e4.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; vsync = 1'b1; valid2 = 1'b0; valid4 = 1'b0;
      ready2 = 1'b1; ready4 = 1'b1; pixel_data = '0; pixel_addr = '0;
      tick(3);
      check("reset sram_req", req2, 0);
      check("reset sram_addr", addr2, 0);
      check("reset sram_data", data2, 0);
      check("reset frame_end", fe2, 0);
      check("reset err_overflow", ovf2, 0);
      check("reset err_vsync", verr2, 0);
      check("reset capture_rst_n", cap2, 0);
      reset = 1'b0;
      tick(2);
      check("wait_act capture_rst_n", cap2, 0);
      vsync = 1'b0; tick(2);
      vsync = 1'b1; tick(3);
      check("capture capture_rst_n", cap2, 1);

      // Two pixels make one word, request lasts a single cycle.
      req_hi2 = 0;
      push2(16'd0, 32'h2211);
      send(0, 8'h11, 16'd0);
      send(0, 8'h22, 16'd1);
      tick(4);
      check("t1 req cycles", req_hi2, 1);
      check("t1 queue drained", q2.size(), 0);

      // PPW=4 marker on lane 2: padded word then frame_end in WAIT_IDLE.
      push4(16'd2, 32'h00D9FFAA);
      send(1, 8'hAA, 16'd8);
      send(1, 8'hFF, 16'd9);
      send(1, 8'hD9, 16'd10);
      wait_fe(1, 1, "t2 frame_end");
      tick(3);
      check("t2 single frame_end", fe4_cnt, 1);
      check("t2 capture_rst_n at frame_end", cap_at_fe4, 0);
      check("t2 queue drained", q4.size(), 0);

      // SRAM stalled: two words buffered, third lost.
      ready2 = 1'b0;
      base = acc2;
      push2(16'd1, 32'h3231);
      push2(16'd2, 32'h3433);
      for (int i = 0; i < 6; i++) send(0, 8'h31 + 8'(i), 16'(2 + i));
      tick(8);
      check("t3 err_overflow", ovf2, 1);
      check("t3 req held", req2, 1);
      check("t3 addr held", addr2, 1);
      ready2 = 1'b1;
      tick(8);
      check("t3 words written", acc2 - base, 2);
      check("t3 queue drained", q2.size(), 0);

      // vsync mid-capture: full word written, partial dropped, frame ends, next frame works.
      base = fe2_cnt;
      push2(16'd4, 32'h4241);
      send(0, 8'h41, 16'd8);
      send(0, 8'h42, 16'd9);
      send(0, 8'h43, 16'd10);
      check("t4 err_vsync before", verr2, 0);
      vsync = 1'b0;
      wait_fe(0, base + 1, "t4 frame_end");
      check("t4 err_vsync", verr2, 1);
      vsync = 1'b1;
      tick(3);
      push2(16'd0, 32'h5251);
      send(0, 8'h51, 16'd0);
      send(0, 8'h52, 16'd1);
      tick(4);
      check("t4 next frame drained", q2.size(), 0);

      // Marker split over a word boundary.
      base = fe2_cnt;
      push2(16'd1, 32'hFF60);
      push2(16'd2, 32'h00D9);
      send(0, 8'h60, 16'd2);
      send(0, 8'hFF, 16'd3);
      send(0, 8'hD9, 16'd4);
      wait_fe(0, base + 1, "t6 frame_end");
      tick(5);
      check("t6 one frame_end", fe2_cnt - base, 1);
      check("t6 queue drained", q2.size(), 0);
      check("dut4 err_overflow clear", ovf4, 0);
      check("dut4 err_vsync set", verr4, 1);

      // Reset with a request outstanding drops the word.
      ready2 = 1'b0;
      send(0, 8'h71, 16'd0);
      send(0, 8'h72, 16'd1);
      check("t5 req pending", req2, 1);
      base = fe2_cnt;
      reset = 1'b1;
      tick(1);
      check("t5 sram_req", req2, 0);
      check("t5 sram_addr", addr2, 0);
      check("t5 sram_data", data2, 0);
      check("t5 frame_end", fe2, 0);
      check("t5 err_overflow", ovf2, 0);
      check("t5 err_vsync", verr2, 0);
      check("t5 capture_rst_n", cap2, 0);
      reset = 1'b0;
      ready2 = 1'b1;
      tick(6);
      check("t5 no frame_end", fe2_cnt - base, 0);
      check("t5 no req", req2, 0);
      check("final q2 empty", q2.size(), 0);
      check("final q4 empty", q4.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
